// File: rtl/svreal_alu_sched_if.sv
// svreal_alu_sched_if
//   Bundles the request and response handshakes of the shared fixed-point
//   arithmetic scheduler.
//   master modport: requester/consumer side (drives requests, rsp_ready)
//   slave modport : scheduler side (drives req_ready and the response)
//   req_valid/req_ready  per-requester handshake, one bit per requester
//   req_op/req_a/req_b   packed per-requester opcode and signed operands
//   rsp_valid/rsp_ready  response handshake
//   rsp_id/rsp_data/rsp_ovf  requester index, result code, saturation/illegal flag
interface svreal_alu_sched_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 18
);
    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [3*N_REQ-1:0]     req_op;
    logic [WIDTH*N_REQ-1:0] req_a;
    logic [WIDTH*N_REQ-1:0] req_b;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [ID_W-1:0]        rsp_id;
    logic [WIDTH-1:0]       rsp_data;
    logic                   rsp_ovf;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_ovf
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data, rsp_ovf
    );
endinterface

// File: rtl/svreal_alu_sched.sv
// svreal_alu_sched
//   Shares one fixed-point arithmetic unit (add/sub/mul/min/max/neg) among
//   N_REQ requesters. A round-robin arbiter picks one request in IDLE, the
//   op runs through PIPE register stages in EXEC, and the result is offered
//   on the response port in RESP until consumed. One op in flight at a time.
//   Ports:
//     clk   clock, all state on rising edge
//     rst   synchronous reset, active-high
//     bus   svreal_alu_sched_if slave modport (request/response handshakes)
//     busy  high whenever the FSM is not in IDLE
module svreal_alu_sched #(
    parameter int N_REQ    = 4,
    parameter int WIDTH    = 18,
    parameter int EXPONENT = -10,
    parameter int PIPE     = 2
) (
    input  logic              clk,
    input  logic              rst,
    svreal_alu_sched_if.slave bus,
    output logic              busy
);
    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = $clog2(PIPE + 1);
    localparam int W2    = 2 * WIDTH;
    localparam int SHIFT = -EXPONENT;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [WIDTH-1:0] MAX_CODE = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_CODE = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [W2-1:0] MAX_W = {{(W2-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [W2-1:0] MIN_W = ~MAX_W;

    logic [1:0]       state;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  id_q;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] pipe_data [PIPE];
    logic             pipe_ovf  [PIPE];

    logic             grant_found;
    logic [ID_W-1:0]  grant_idx;
    logic [ID_W-1:0]  cand;
    logic             accept;

    logic [2:0]        g_op;
    logic [WIDTH-1:0]  g_a;
    logic [WIDTH-1:0]  g_b;
    logic [WIDTH:0]    sum_ext;
    logic signed [W2-1:0] prod;
    logic signed [W2-1:0] prod_sh;
    logic signed [W2-1:0] wide;
    logic              b_lt_a;
    logic              illegal;
    logic [WIDTH-1:0]  alu_data;
    logic              alu_ovf;

    function automatic logic signed [W2-1:0] sext1(input logic [WIDTH:0] v);
        return {{(W2-WIDTH-1){v[WIDTH]}}, v};
    endfunction

    // Round-robin search starting at rr_ptr; first valid requester wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = ID_W'((int'(rr_ptr) + k) % N_REQ);
            if (!grant_found && bus.req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Grant is suppressed while rst is high so a requester never sees an
    // acceptance that the reset would immediately discard.
    assign accept = (state == S_IDLE) && grant_found && !rst;

    always_comb begin
        bus.req_ready = '0;
        if (accept) begin
            bus.req_ready[grant_idx] = 1'b1;
        end
    end

    // The first pipeline stage computes straight from the granted request's
    // operands, so the operand capture and stage 0 are the same register.
    always_comb begin
        g_op    = bus.req_op[3*grant_idx +: 3];
        g_a     = bus.req_a[WIDTH*grant_idx +: WIDTH];
        g_b     = bus.req_b[WIDTH*grant_idx +: WIDTH];
        sum_ext = '0;
        prod    = $signed({{WIDTH{g_a[WIDTH-1]}}, g_a}) * $signed({{WIDTH{g_b[WIDTH-1]}}, g_b});
        prod_sh = prod >>> SHIFT;
        b_lt_a  = $signed(g_b) < $signed(g_a);
        illegal = g_op[2] & g_op[1];
        wide    = '0;
        case (g_op)
            3'd0: begin
                sum_ext = {g_a[WIDTH-1], g_a} + {g_b[WIDTH-1], g_b};
                wide    = sext1(sum_ext);
            end
            3'd1: begin
                sum_ext = {g_a[WIDTH-1], g_a} - {g_b[WIDTH-1], g_b};
                wide    = sext1(sum_ext);
            end
            3'd2: wide = prod_sh;
            3'd3: wide = b_lt_a ? sext1({g_b[WIDTH-1], g_b}) : sext1({g_a[WIDTH-1], g_a});
            3'd4: wide = (!b_lt_a && (g_b != g_a)) ? sext1({g_b[WIDTH-1], g_b})
                                                   : sext1({g_a[WIDTH-1], g_a});
            3'd5: begin
                sum_ext = '0 - {g_a[WIDTH-1], g_a};
                wide    = sext1(sum_ext);
            end
            default: wide = '0;
        endcase

        if (illegal) begin
            alu_data = '0;
            alu_ovf  = 1'b1;
        end else if (wide > MAX_W) begin
            alu_data = MAX_CODE;
            alu_ovf  = 1'b1;
        end else if (wide < MIN_W) begin
            alu_data = MIN_CODE;
            alu_ovf  = 1'b1;
        end else begin
            alu_data = wide[WIDTH-1:0];
            alu_ovf  = 1'b0;
        end
    end

    // Results advance one stage per cycle; only stage 0 is gated by accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PIPE; i++) begin
                pipe_data[i] <= '0;
                pipe_ovf[i]  <= 1'b0;
            end
        end else begin
            if (accept) begin
                pipe_data[0] <= alu_data;
                pipe_ovf[0]  <= alu_ovf;
            end
            for (int i = 1; i < PIPE; i++) begin
                pipe_data[i] <= pipe_data[i-1];
                pipe_ovf[i]  <= pipe_ovf[i-1];
            end
        end
    end

    // Single-issue sequencer: IDLE -> EXEC (PIPE cycles) -> RESP -> IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            rr_ptr       <= '0;
            id_q         <= '0;
            cnt          <= '0;
            bus.rsp_id   <= '0;
            bus.rsp_data <= '0;
            bus.rsp_ovf  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_found) begin
                        id_q   <= grant_idx;
                        rr_ptr <= (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
                        cnt    <= CNT_W'(PIPE);
                        state  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (cnt == CNT_W'(1)) begin
                        bus.rsp_id   <= id_q;
                        bus.rsp_data <= pipe_data[PIPE-1];
                        bus.rsp_ovf  <= pipe_ovf[PIPE-1];
                        state        <= S_RESP;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.rsp_valid = (state == S_RESP);
    assign busy          = (state != S_IDLE);

endmodule

// File: tb/tb_svreal_alu_sched.sv
// tb_svreal_alu_sched
//   Directed, table-driven bench for svreal_alu_sched (N_REQ=4, WIDTH=18,
//   EXPONENT=-10, PIPE=2; 1.0 = 1024). Inputs change on the falling edge,
//   outputs are sampled 1 ns later.
module tb_svreal_alu_sched;
    localparam int N_REQ    = 4;
    localparam int WIDTH    = 18;
    localparam int EXPONENT = -10;
    localparam int PIPE     = 2;
    localparam int N_VEC    = 17;

    typedef struct {
        int id;
        int op;
        int a;
        int b;
        int exp_data;
        int exp_ovf;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
    int   n_cmp = 0;
    int   n_miss = 0;
    int   cyc = 0;
    vec_t vecs [N_VEC];

    always #5 clk = ~clk;
    always @(negedge clk) cyc++;

    svreal_alu_sched_if #(.N_REQ(N_REQ), .WIDTH(WIDTH)) bus ();

    svreal_alu_sched #(
        .N_REQ(N_REQ), .WIDTH(WIDTH), .EXPONENT(EXPONENT), .PIPE(PIPE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .busy(busy)
    );

    task automatic checkOutput(input string name, input logic signed [63:0] act,
                               input logic signed [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clearInputs();
        bus.req_valid = '0;
        bus.req_op    = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
    endtask

    task automatic driveReq(input int id, input int op, input int a, input int b);
        bus.req_op[3*id +: 3]         = 3'(op);
        bus.req_a[WIDTH*id +: WIDTH]  = WIDTH'(a);
        bus.req_b[WIDTH*id +: WIDTH]  = WIDTH'(b);
        bus.req_valid[id]             = 1'b1;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One request from one requester, checked for latency and result.
    task automatic applyStimulus(input vec_t v);
        int waitc;
        int lat;
        @(negedge clk);
        clearInputs();
        driveReq(v.id, v.op, v.a, v.b);
        #1;
        waitc = 0;
        while (!bus.req_ready[v.id] && waitc < 20) begin
            @(negedge clk);
            #1;
            waitc++;
        end
        checkOutput("grant", bus.req_ready[v.id], 1);
        @(negedge clk);
        clearInputs();
        #1;
        lat = 1;
        while (!bus.rsp_valid && lat < 20) begin
            @(negedge clk);
            #1;
            lat++;
        end
        checkOutput("rsp_valid", bus.rsp_valid, 1);
        checkOutput("latency", lat, PIPE + 1);
        checkOutput("rsp_data", $signed(bus.rsp_data), v.exp_data);
        checkOutput("rsp_ovf", bus.rsp_ovf, v.exp_ovf);
        checkOutput("rsp_id", bus.rsp_id, v.id);
        @(negedge clk);
        #1;
        checkOutput("rsp_valid drop", bus.rsp_valid, 0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int order [5];
        int n_grant;
        int n_rsp;
        int both;
        int last;
        int waitc;
        int idle_rsp;
        logic [3:0] cur;
        logic [3:0] prev;
        logic [3:0] expg;

        //            id op  a        b      data     ovf
        vecs[0]  = '{0, 0, 1024,    512,   1536,    0};
        vecs[1]  = '{1, 2, 2048,    -1536, -3072,   0};
        vecs[2]  = '{2, 2, -1,      1,     -1,      0};
        vecs[3]  = '{3, 2, 131071,  2048,  131071,  1};
        vecs[4]  = '{0, 0, 131071,  1,     131071,  1};
        vecs[5]  = '{1, 1, -131072, 1,     -131072, 1};
        vecs[6]  = '{2, 5, -131072, 0,     131071,  1};
        vecs[7]  = '{3, 6, 100,     200,   0,       1};
        vecs[8]  = '{0, 7, 5,       5,     0,       1};
        vecs[9]  = '{1, 3, 300,     -200,  -200,    0};
        vecs[10] = '{2, 4, 300,     -200,  300,     0};
        vecs[11] = '{3, 3, 7,       7,     7,       0};
        vecs[12] = '{0, 1, 1000,    3000,  -2000,   0};
        vecs[13] = '{1, 5, 1024,    99,    -1024,   0};
        vecs[14] = '{2, 2, -1024,   -1024, 1024,    0};
        vecs[15] = '{3, 2, -3,      1,     -1,      0};
        vecs[16] = '{0, 0, -131072, -1,    -131072, 1};
        order = '{0, 1, 2, 3, 0};

        rst = 1'b1;
        bus.rsp_ready = 1'b1;
        clearInputs();
        repeat (2) @(negedge clk);
        bus.req_valid[0] = 1'b1;
        #1;
        checkOutput("reset rsp_valid", bus.rsp_valid, 0);
        checkOutput("reset rsp_id", bus.rsp_id, 0);
        checkOutput("reset rsp_data", $signed(bus.rsp_data), 0);
        checkOutput("reset rsp_ovf", bus.rsp_ovf, 0);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset req_ready", bus.req_ready, 0);
        @(negedge clk);
        clearInputs();
        rst = 1'b0;

        for (int i = 0; i < N_VEC; i++) begin
            applyStimulus(vecs[i]);
        end

        // All four requesters held valid: strict rotation, one grant per PIPE+2.
        doReset();
        for (int id = 0; id < N_REQ; id++) driveReq(id, 0, id * 10, 100);
        n_grant = 0;
        n_rsp = 0;
        both = 0;
        last = 0;
        prev = '0;
        for (int c = 0; c < 60 && n_rsp < 5; c++) begin
            #1;
            cur = bus.req_ready;
            if (cur != 0 && n_grant < 5) begin
                expg = 4'b0001 << order[n_grant];
                checkOutput("rr grant", cur, expg);
                if (n_grant > 0) checkOutput("grant spacing", cyc - last, PIPE + 2);
                last = cyc;
                n_grant++;
            end
            if (cur != 0 && prev != 0) both++;
            if (bus.rsp_valid && n_rsp < 5) begin
                checkOutput("rr rsp_id", bus.rsp_id, order[n_rsp]);
                checkOutput("rr rsp_data", $signed(bus.rsp_data), order[n_rsp] * 10 + 100);
                n_rsp++;
            end
            prev = cur;
            @(negedge clk);
        end
        clearInputs();
        checkOutput("rr responses", n_rsp, 5);
        checkOutput("ready consecutive", both, 0);

        // Back-pressure: response held stable while rsp_ready is low.
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        driveReq(1, 0, 10, 20);
        #1;
        waitc = 0;
        while (!bus.req_ready[1] && waitc < 20) begin
            @(negedge clk);
            #1;
            waitc++;
        end
        checkOutput("hold grant", bus.req_ready[1], 1);
        @(negedge clk);
        for (int id = 0; id < N_REQ; id++) driveReq(id, 0, 1, 1);
        #1;
        waitc = 0;
        while (!bus.rsp_valid && waitc < 20) begin
            @(negedge clk);
            #1;
            waitc++;
        end
        for (int i = 0; i < 5; i++) begin
            checkOutput("hold rsp_valid", bus.rsp_valid, 1);
            checkOutput("hold rsp_data", $signed(bus.rsp_data), 30);
            checkOutput("hold rsp_id", bus.rsp_id, 1);
            checkOutput("hold rsp_ovf", bus.rsp_ovf, 0);
            checkOutput("hold req_ready", bus.req_ready, 0);
            checkOutput("hold busy", busy, 1);
            @(negedge clk);
            #1;
        end
        clearInputs();
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("release busy", busy, 0);
        checkOutput("release rsp_valid", bus.rsp_valid, 0);

        // Reset while req2 is executing: op dropped, arbiter pointer back to 0.
        doReset();
        driveReq(2, 0, 1, 1);
        #1;
        waitc = 0;
        while (!bus.req_ready[2] && waitc < 20) begin
            @(negedge clk);
            #1;
            waitc++;
        end
        checkOutput("req2 grant", bus.req_ready[2], 1);
        @(negedge clk);
        clearInputs();
        rst = 1'b1;
        #1;
        checkOutput("exec busy", busy, 1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("post-rst busy", busy, 0);
        checkOutput("post-rst rsp_valid", bus.rsp_valid, 0);
        idle_rsp = 0;
        repeat (6) begin
            if (bus.rsp_valid) idle_rsp++;
            @(negedge clk);
            #1;
        end
        checkOutput("no rsp after rst", idle_rsp, 0);
        driveReq(1, 1, 500, 200);
        driveReq(3, 0, 7, 7);
        #1;
        checkOutput("post-rst grant", bus.req_ready, 4'b0010);
        @(negedge clk);
        clearInputs();
        #1;
        waitc = 0;
        while (!bus.rsp_valid && waitc < 20) begin
            @(negedge clk);
            #1;
            waitc++;
        end
        checkOutput("post-rst rsp_id", bus.rsp_id, 1);
        checkOutput("post-rst rsp_data", $signed(bus.rsp_data), 300);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
        $finish;
    end
endmodule
